bf16_cmd_sequencer: RTL

Command sequencer between the SPI word receiver and the bfloat16 arithmetic unit inside bfloat16_processor. It takes 16-bit words already deserialised by the SPI front end and decodes opcodes 0x0–0xA. It collects each opcode's operands, issues one or two operations to a shared add/sub/mul/div unit over a start/done handshake, and owns the accumulator. Results are handed to the SPI transmit path.

---
 rtl/bf16_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bf16_cmd_sequencer.sv
// Command sequencer between the SPI word receiver and the shared bfloat16 ALU.
// Decodes opcodes 0x0-0xA, gathers operands, drives the ALU handshake and owns the accumulator.
module bf16_cmd_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [15:0] acc,
  output logic [15:0] tx_data,
  output logic        tx_load,
  output logic        ready,
  output logic        err
);

  localparam int unsigned W  = 16;
  localparam int unsigned TW = 16;

  localparam logic [3:0] OP_ZERO = 4'h0;
  localparam logic [3:0] OP_SET  = 4'h1;
  localparam logic [3:0] OP_LOAD = 4'h2;
  localparam logic [3:0] OP_ADD2 = 4'h3;
  localparam logic [3:0] OP_SUB2 = 4'h4;
  localparam logic [3:0] OP_MPY2 = 4'h5;
  localparam logic [3:0] OP_DIV2 = 4'h6;
  localparam logic [3:0] OP_SUM  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_MAC  = 4'h9;
  localparam logic [3:0] OP_MAS  = 4'hA;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_ISSUE, S_WAIT, S_ISSUE2, S_WAIT2, S_WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  res_q, res_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  tx_data_q, tx_data_d;
  logic          tx_load_q, tx_load_d;
  logic          err_q, err_d;
  logic          alu_start_q, alu_start_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;

  logic cmd_chained;
  assign cmd_chained = (cmd_q == OP_MAC) || (cmd_q == OP_MAS);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      opa_q       <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      opa_q       <= opa_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      err_q       <= err_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    opa_d       = opa_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    err_d       = 1'b0;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if ((rx_data[15:4] != '0) || (rx_data[3:0] > OP_MAS)) begin
            err_d = 1'b1;
          end else if (rx_data[3:0] == OP_ZERO) begin
            acc_d     = '0;
            tx_data_d = '0;
            tx_load_d = 1'b1;
          end else if (rx_data[3:0] == OP_LOAD) begin
            tx_data_d = acc_q;
            tx_load_d = 1'b1;
          end else begin
            cmd_d   = rx_data[3:0];
            state_d = S_GET_A;
          end
        end
      end

      S_GET_A: begin
        if (rx_valid) begin
          opa_d = rx_data;
          case (cmd_q)
            OP_SET: begin
              acc_d     = rx_data;
              tx_data_d = rx_data;
              tx_load_d = 1'b1;
              state_d   = S_IDLE;
            end
            OP_SUM, OP_SUB: begin
              alu_a_d     = acc_q;
              alu_b_d     = rx_data;
              alu_op_d    = (cmd_q == OP_SUM) ? ALU_ADD : ALU_SUB;
              alu_start_d = 1'b1;
              state_d     = S_ISSUE;
            end
            default: state_d = S_GET_B;
          endcase
        end
      end

      S_GET_B: begin
        if (rx_valid) begin
          alu_a_d     = opa_q;
          alu_b_d     = rx_data;
          alu_start_d = 1'b1;
          state_d     = S_ISSUE;
          case (cmd_q)
            OP_ADD2: alu_op_d = ALU_ADD;
            OP_SUB2: alu_op_d = ALU_SUB;
            OP_MPY2: alu_op_d = ALU_MUL;
            OP_DIV2: alu_op_d = ALU_DIV;
            default: alu_op_d = ALU_MUL;
          endcase
        end
      end

      S_ISSUE, S_ISSUE2: begin
        err_d   = rx_valid;
        cnt_d   = '0;
        state_d = (state_q == S_ISSUE) ? S_WAIT : S_WAIT2;
      end

      S_WAIT, S_WAIT2: begin
        err_d = rx_valid;
        if (alu_done) begin
          // The product of a MAC/MAS is folded into acc by a second ALU pass.
          if ((state_q == S_WAIT) && cmd_chained) begin
            alu_a_d     = acc_q;
            alu_b_d     = alu_result;
            alu_op_d    = (cmd_q == OP_MAC) ? ALU_ADD : ALU_SUB;
            alu_start_d = 1'b1;
            state_d     = S_ISSUE2;
          end else begin
            res_d   = alu_result;
            state_d = S_WRITE;
          end
        end else if (cnt_q == TW'(ALU_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_WRITE: begin
        err_d     = rx_valid;
        acc_d     = res_q;
        tx_data_d = res_q;
        tx_load_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign acc       = acc_q;
  assign tx_data   = tx_data_q;
  assign tx_load   = tx_load_q;
  assign err       = err_q;
  assign ready     = (state_q == S_IDLE);

endmodule
